// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the tiled systolic-array sequencer.
package sys_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        TDONE,
        DONE
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Cycles from the last operand leaving the skew lines until the far PE has accumulated it.
    function automatic int drain_cycles(input int w, input int l, input int pe_lat);
        return w + l + pe_lat - 1;
    endfunction

endpackage

// File: rtl/sys_array_skew_line.sv
// Lane skew: lane i of in_dat appears on out_dat after i cycles; lane 0 passes straight through.
// Latency i cycles per lane; no backpressure, shifts every cycle.
module sys_array_skew_line
    import sys_array_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LANES*DATA_WIDTH-1:0] in_dat,
    output logic [LANES*DATA_WIDTH-1:0] out_dat
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign out_dat[DATA_WIDTH-1:0] = in_dat[DATA_WIDTH-1:0];
        end else begin : g_dly
            logic [i*DATA_WIDTH-1:0]     sr_q;
            logic [i*DATA_WIDTH-1:0]     sr_d;
            logic [(i+1)*DATA_WIDTH-1:0] chain;

            assign chain = {sr_q, in_dat[i*DATA_WIDTH +: DATA_WIDTH]};

            always_comb begin
                sr_d = chain[i*DATA_WIDTH-1:0];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sr_q <= '0;
                else          sr_q <= sr_d;
            end

            assign out_dat[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[i*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/sys_array_tile_sequencer.sv
// Tiled C=W*B feeder for a fixed systolic array: reads, masks and skews operand slices per tile.
// Per tile K feed + D drain + 1 report cycles; no backpressure, buffers answer 1 cycle after read.
// Optional SYS_ARRAY_PERF_CNT_EN adds a saturating 32-bit busy-cycle counter on perf_cycles.
module sys_array_tile_sequencer
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ARRAY_MAX_W = 4,
    parameter int ARRAY_MAX_L = 4,
    parameter int MAX_DIM     = 64,
    parameter int DIM_W       = 7,
    parameter int ADDR_W      = 12,
    parameter int PE_LATENCY  = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              load_params,
    input  logic [DIM_W-1:0]                  cfg_m,
    input  logic [DIM_W-1:0]                  cfg_k,
    input  logic [DIM_W-1:0]                  cfg_n,
    input  logic                              start_comp,
    output logic                              ready,
    output logic                              done,
    output logic                              w_rd_en,
    output logic [ADDR_W-1:0]                 w_rd_addr,
    input  logic [ARRAY_MAX_W*DATA_WIDTH-1:0] w_rd_data,
    output logic                              b_rd_en,
    output logic [ADDR_W-1:0]                 b_rd_addr,
    input  logic [ARRAY_MAX_L*DATA_WIDTH-1:0] b_rd_data,
    output logic [ARRAY_MAX_W*DATA_WIDTH-1:0] sa_w_out,
    output logic [ARRAY_MAX_L*DATA_WIDTH-1:0] sa_b_out,
    output logic                              sa_clear,
    output logic                              tile_done,
    output logic [DIM_W-1:0]                  tile_row,
    output logic [DIM_W-1:0]                  tile_col
`ifdef SYS_ARRAY_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_cycles
`endif
);

    localparam int AW    = ARRAY_MAX_W;
    localparam int AL    = ARRAY_MAX_L;
    localparam int D     = drain_cycles(ARRAY_MAX_W, ARRAY_MAX_L, PE_LATENCY);
    localparam int CNT_W = 8;

    function automatic logic [DIM_W-1:0] sat_dim(input logic [DIM_W-1:0] v);
        return (int'(v) > MAX_DIM) ? DIM_W'(MAX_DIM) : v;
    endfunction

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   cfg_m_q, cfg_m_d, cfg_k_q, cfg_k_d, cfg_n_q, cfg_n_d;
    logic [DIM_W-1:0]   tile_r_q, tile_r_d, tile_c_q, tile_c_d, kk_q, kk_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic               w_vld_q, w_vld_d, b_vld_q, b_vld_d;
    logic [AW-1:0]      w_ok_q, w_ok_d;
    logic [AL-1:0]      b_ok_q, b_ok_d;
    logic [DIM_W-1:0]   tr_last, tc_last;
    logic [AW*DATA_WIDTH-1:0] w_lane_dat;
    logic [AL*DATA_WIDTH-1:0] b_lane_dat;

    assign tr_last = DIM_W'(ceil_div(int'(cfg_m_q), AW) - 1);
    assign tc_last = DIM_W'(ceil_div(int'(cfg_n_q), AL) - 1);

    always_comb begin
        state_d   = state_q;
        cfg_m_d   = cfg_m_q;
        cfg_k_d   = cfg_k_q;
        cfg_n_d   = cfg_n_q;
        tile_r_d  = tile_r_q;
        tile_c_d  = tile_c_q;
        kk_d      = kk_q;
        drain_d   = drain_q;
        w_vld_d   = 1'b0;
        b_vld_d   = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        w_rd_en   = 1'b0;
        b_rd_en   = 1'b0;
        w_rd_addr = '0;
        b_rd_addr = '0;
        sa_clear  = 1'b0;
        tile_done = 1'b0;
        tile_row  = '0;
        tile_col  = '0;
        // Lane masks are captured with the read so they line up with the returning data.
        for (int i = 0; i < AW; i++) w_ok_d[i] = (int'(tile_r_q) * AW + i) < int'(cfg_m_q);
        for (int j = 0; j < AL; j++) b_ok_d[j] = (int'(tile_c_q) * AL + j) < int'(cfg_n_q);

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load_params) begin
                    cfg_m_d = sat_dim(cfg_m);
                    cfg_k_d = sat_dim(cfg_k);
                    cfg_n_d = sat_dim(cfg_n);
                end
                if (start_comp) begin
                    tile_r_d = '0;
                    tile_c_d = '0;
                    kk_d     = '0;
                    drain_d  = '0;
                    if (cfg_m_q == '0 || cfg_k_q == '0 || cfg_n_q == '0) state_d = DONE;
                    else                                                 state_d = FEED;
                end
            end
            FEED: begin
                w_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                w_rd_addr = ADDR_W'(tile_r_q) * ADDR_W'(cfg_k_q) + ADDR_W'(kk_q);
                b_rd_addr = ADDR_W'(tile_c_q) * ADDR_W'(cfg_k_q) + ADDR_W'(kk_q);
                w_vld_d   = 1'b1;
                b_vld_d   = 1'b1;
                sa_clear  = (kk_q == '0);
                kk_d      = kk_q + DIM_W'(1);
                if (kk_q == cfg_k_q - DIM_W'(1)) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + CNT_W'(1);
                if (drain_q == CNT_W'(D - 1)) state_d = TDONE;
            end
            TDONE: begin
                tile_done = 1'b1;
                tile_row  = tile_r_q;
                tile_col  = tile_c_q;
                kk_d      = '0;
                if (tile_c_q == tc_last) begin
                    tile_c_d = '0;
                    if (tile_r_q == tr_last) begin
                        state_d = DONE;
                    end else begin
                        tile_r_d = tile_r_q + DIM_W'(1);
                        state_d  = FEED;
                    end
                end else begin
                    tile_c_d = tile_c_q + DIM_W'(1);
                    state_d  = FEED;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_lane_dat = '0;
        b_lane_dat = '0;
        for (int i = 0; i < AW; i++)
            if (w_vld_q && w_ok_q[i]) w_lane_dat[i*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 0; j < AL; j++)
            if (b_vld_q && b_ok_q[j]) b_lane_dat[j*DATA_WIDTH +: DATA_WIDTH] = b_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cfg_m_q  <= '0;
            cfg_k_q  <= '0;
            cfg_n_q  <= '0;
            tile_r_q <= '0;
            tile_c_q <= '0;
            kk_q     <= '0;
            drain_q  <= '0;
            w_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            w_ok_q   <= '0;
            b_ok_q   <= '0;
        end else begin
            state_q  <= state_d;
            cfg_m_q  <= cfg_m_d;
            cfg_k_q  <= cfg_k_d;
            cfg_n_q  <= cfg_n_d;
            tile_r_q <= tile_r_d;
            tile_c_q <= tile_c_d;
            kk_q     <= kk_d;
            drain_q  <= drain_d;
            w_vld_q  <= w_vld_d;
            b_vld_q  <= b_vld_d;
            w_ok_q   <= w_ok_d;
            b_ok_q   <= b_ok_d;
        end
    end

    sys_array_skew_line #(.LANES(AW), .DATA_WIDTH(DATA_WIDTH)) u_w_skew (
        .clk     (clk),
        .reset_n (reset_n),
        .in_dat  (w_lane_dat),
        .out_dat (sa_w_out)
    );

    sys_array_skew_line #(.LANES(AL), .DATA_WIDTH(DATA_WIDTH)) u_b_skew (
        .clk     (clk),
        .reset_n (reset_n),
        .in_dat  (b_lane_dat),
        .out_dat (sa_b_out)
    );

`ifdef SYS_ARRAY_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start_comp)      perf_d = '0;
        else if (state_q != IDLE && perf_q != '1) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perf_q <= '0;
        else          perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sys_array_tile_sequencer.sv
// Bench for sys_array_tile_sequencer: buffer models, a 4x4 output-stationary array model and a tile scoreboard.
module tb_sys_array_tile_sequencer;

    localparam int DW = 8, AW = 4, AL = 4, DIM_W = 7, ADDR_W = 12;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 load_params, start_comp;
    logic [DIM_W-1:0]     cfg_m, cfg_k, cfg_n;
    logic                 ready, done, w_rd_en, b_rd_en, sa_clear, tile_done;
    logic [ADDR_W-1:0]    w_rd_addr, b_rd_addr;
    logic [AW*DW-1:0]     w_rd_data, sa_w_out;
    logic [AL*DW-1:0]     b_rd_data, sa_b_out;
    logic [DIM_W-1:0]     tile_row, tile_col;
`ifdef SYS_ARRAY_PERF_CNT_EN
    logic [31:0]          perf_cycles;
`endif

    always #5 clk = ~clk;

    sys_array_tile_sequencer dut (
        .clk(clk), .reset_n(reset_n), .load_params(load_params),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .start_comp(start_comp),
        .ready(ready), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .sa_w_out(sa_w_out), .sa_b_out(sa_b_out), .sa_clear(sa_clear),
        .tile_done(tile_done), .tile_row(tile_row), .tile_col(tile_col)
`ifdef SYS_ARRAY_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int vectors = 0, miscompares = 0;
    int Wm [8][8];
    int Bm [8][8];
    logic [31:0] wmem [256];
    logic [31:0] bmem [256];
    int exp_tr_q[$], exp_tc_q[$], exp_c_q[$], exp_wa_q[$], exp_ba_q[$];
    int g_m, g_k, g_n, g_tr, g_tc;
    int r_done, r_tiles, r_reads, r_ready, r_viol, r_clear1, r_nclear, r_lane3, r_tdone;

    // Buffers: registered read, one cycle latency.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr[7:0]];
        if (b_rd_en) b_rd_data <= bmem[b_rd_addr[7:0]];
    end

    // Output-stationary array: weights move right, data moves down, one hop per cycle.
    logic [7:0] aw_q [4][4];
    logic [7:0] ab_q [4][4];
    int         acc  [4][4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin : pe
                logic [7:0] win;
                logic [7:0] bin;
                if (j == 0) win = sa_w_out[i*8 +: 8]; else win = aw_q[i][j-1];
                if (i == 0) bin = sa_b_out[j*8 +: 8]; else bin = ab_q[i-1][j];
                aw_q[i][j] <= win;
                ab_q[i][j] <= bin;
                if (sa_clear) acc[i][j] <= 0;
                else          acc[i][j] <= acc[i][j] + int'(win) * int'(bin);
            end
        end
    end

    task automatic setup(input int m, input int k, input int n);
        logic [31:0] word;
        g_m = m; g_k = k; g_n = n;
        g_tr = (m + 3) / 4; g_tc = (n + 3) / 4;
        exp_tr_q.delete(); exp_tc_q.delete(); exp_c_q.delete();
        exp_wa_q.delete(); exp_ba_q.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                Wm[r][c] = int'($urandom_range(1, 15));
                Bm[r][c] = int'($urandom_range(1, 15));
            end
        for (int a = 0; a < 256; a++) begin
            wmem[a] = 32'hA5A5A5A5;
            bmem[a] = 32'h5A5A5A5A;
        end
        for (int t = 0; t < 2; t++)
            for (int kk = 0; kk < k; kk++) begin
                word = 32'hA5A5A5A5;
                for (int i = 0; i < 4; i++)
                    if (t*4 + i < m) word[i*8 +: 8] = 8'(Wm[t*4+i][kk]);
                wmem[t*k + kk] = word;
                word = 32'h5A5A5A5A;
                for (int j = 0; j < 4; j++)
                    if (t*4 + j < n) word[j*8 +: 8] = 8'(Bm[kk][t*4+j]);
                bmem[t*k + kk] = word;
            end
        if (m != 0 && k != 0 && n != 0)
            for (int tr = 0; tr < g_tr; tr++)
                for (int tc = 0; tc < g_tc; tc++) begin
                    exp_tr_q.push_back(tr);
                    exp_tc_q.push_back(tc);
                    for (int kk = 0; kk < k; kk++) begin
                        exp_wa_q.push_back(tr*k + kk);
                        exp_ba_q.push_back(tc*k + kk);
                    end
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) begin
                            int s;
                            s = 0;
                            if (tr*4 + i < m && tc*4 + j < n)
                                for (int kk = 0; kk < k; kk++) s += Wm[tr*4+i][kk] * Bm[kk][tc*4+j];
                            exp_c_q.push_back(s);
                        end
                end
    endtask

    task automatic load_cfg(input int m, input int k, input int n);
        @(negedge clk);
        cfg_m = DIM_W'(m); cfg_k = DIM_W'(k); cfg_n = DIM_W'(n);
        load_params = 1'b1;
        @(posedge clk);
        #1 load_params = 1'b0;
    endtask

    // Start a job and follow it cycle by cycle until ready returns after done.
    task automatic run_job(input int inject_cyc, input int budget);
        logic fin;
        int   wa, ba, c, er, ec;
        r_done = 0; r_tiles = 0; r_reads = 0; r_ready = 0; r_viol = 0;
        r_clear1 = 0; r_nclear = 0; r_lane3 = 0; r_tdone = 0;
        fin = 1'b0;
        @(negedge clk);
        start_comp = 1'b1;
        @(posedge clk);
        #1 start_comp = 1'b0;
        for (int t = 1; t <= budget && !fin; t++) begin
            @(negedge clk);
            if (t == inject_cyc) begin
                start_comp = 1'b1; load_params = 1'b1; cfg_m = 7'd9;
            end else if (t == inject_cyc + 1) begin
                start_comp = 1'b0; load_params = 1'b0;
            end
            if (sa_clear) begin
                r_nclear++;
                if (r_clear1 == 0) r_clear1 = t;
            end
            if (r_lane3 == 0 && sa_w_out[31:24] != 8'd0) r_lane3 = t;
            if (r_tiles >= g_tc)
                for (int i = 0; i < 4; i++)
                    if (4 + i >= g_m && sa_w_out[i*8 +: 8] != 8'd0) r_viol++;
            if (w_rd_en) begin
                r_reads++;
                vectors++;
                if (exp_wa_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_extra cycle %0d: got w_rd_addr %0d, required no read", t, w_rd_addr);
                end else begin
                    wa = exp_wa_q.pop_front();
                    ba = exp_ba_q.pop_front();
                    if (w_rd_addr !== ADDR_W'(wa) || b_rd_addr !== ADDR_W'(ba) || b_rd_en !== 1'b1) begin
                        miscompares++;
                        $display("FAIL read_addr cycle %0d: got w=%0d b=%0d b_en=%b, required w=%0d b=%0d b_en=1",
                                 t, w_rd_addr, b_rd_addr, b_rd_en, wa, ba);
                    end
                end
            end
            if (tile_done) begin
                r_tiles++;
                if (r_tdone == 0) r_tdone = t;
                vectors++;
                if (exp_tr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tile_extra cycle %0d: got tile (%0d,%0d), required none", t, tile_row, tile_col);
                end else begin
                    er = exp_tr_q.pop_front();
                    ec = exp_tc_q.pop_front();
                    if (tile_row !== DIM_W'(er) || tile_col !== DIM_W'(ec)) begin
                        miscompares++;
                        $display("FAIL tile_idx cycle %0d: got (%0d,%0d), required (%0d,%0d)", t, tile_row, tile_col, er, ec);
                    end
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) begin
                            c = exp_c_q.pop_front();
                            vectors++;
                            if (acc[i][j] !== c) begin
                                miscompares++;
                                $display("FAIL c_elem tile (%0d,%0d) pe[%0d][%0d]: got %0d, required %0d", er, ec, i, j, acc[i][j], c);
                            end
                        end
                end
            end
            if (done) r_done = t;
            if (r_done != 0 && t > r_done && ready) begin
                r_ready = t;
                fin = 1'b1;
            end
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL job_timeout: got no done/ready within %0d cycles, required completion", budget);
        end
        vectors++;
        if (exp_tr_q.size() != 0 || exp_wa_q.size() != 0) begin
            miscompares++;
            $display("FAIL job_leftover: got %0d tiles and %0d reads outstanding, required 0", exp_tr_q.size(), exp_wa_q.size());
        end
    endtask

    task automatic test_reset();
        logic [107:0] outs;
        reset_n = 1'b0; load_params = 1'b0; start_comp = 1'b0;
        cfg_m = '0; cfg_k = '0; cfg_n = '0;
        repeat (3) @(negedge clk);
        outs = {ready, done, tile_done, w_rd_en, b_rd_en, sa_clear, w_rd_addr, b_rd_addr,
                sa_w_out, sa_b_out, tile_row, tile_col};
        vectors++;
        if (outs !== {1'b1, 107'd0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required %h", outs, {1'b1, 107'd0});
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b done=%b, required ready=1 done=0", ready, done);
        end
    endtask

    task automatic test_single_tile();
        load_cfg(4, 4, 4);
        setup(4, 4, 4);
        run_job(0, 200);
        vectors++;
        if (r_reads != 4 || r_clear1 != 1 || r_nclear != 1) begin
            miscompares++;
            $display("FAIL single_feed: got reads=%0d clear_at=%0d clears=%0d, required 4/1/1", r_reads, r_clear1, r_nclear);
        end
        vectors++;
        if (r_lane3 != 5) begin
            miscompares++;
            $display("FAIL single_lane3: got first cycle %0d, required 5", r_lane3);
        end
        vectors++;
        if (r_tdone != 13 || r_tiles != 1 || r_done != 14 || r_ready != 15) begin
            miscompares++;
            $display("FAIL single_timing: got tile_done=%0d tiles=%0d done=%0d ready=%0d, required 13/1/14/15",
                     r_tdone, r_tiles, r_done, r_ready);
        end
`ifdef SYS_ARRAY_PERF_CNT_EN
        vectors++;
        if (perf_cycles !== 32'd14) begin
            miscompares++;
            $display("FAIL perf_after_done: got %0d, required 14", perf_cycles);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (perf_cycles !== 32'd14) begin
            miscompares++;
            $display("FAIL perf_hold: got %0d, required 14", perf_cycles);
        end
`endif
    endtask

    task automatic test_partial_tiles();
        load_cfg(6, 3, 5);
        setup(6, 3, 5);
        run_job(0, 400);
        vectors++;
        if (r_tiles != 4 || r_reads != 12 || r_nclear != 4) begin
            miscompares++;
            $display("FAIL partial_counts: got tiles=%0d reads=%0d clears=%0d, required 4/12/4", r_tiles, r_reads, r_nclear);
        end
        vectors++;
        if (r_viol != 0) begin
            miscompares++;
            $display("FAIL partial_wmask: got %0d nonzero masked weight lanes, required 0", r_viol);
        end
    endtask

    task automatic test_zero_dim();
        load_cfg(4, 0, 4);
        setup(4, 0, 4);
        run_job(0, 50);
        vectors++;
        if (r_done != 1 || r_ready != 2 || r_reads != 0 || r_tiles != 0) begin
            miscompares++;
            $display("FAIL zero_dim: got done=%0d ready=%0d reads=%0d tiles=%0d, required 1/2/0/0",
                     r_done, r_ready, r_reads, r_tiles);
        end
    endtask

    task automatic test_busy_cmds();
        int bad;
        load_cfg(4, 4, 4);
        setup(4, 4, 4);
        run_job(2, 200);
        vectors++;
        if (r_tiles != 1 || r_done != 14) begin
            miscompares++;
            $display("FAIL busy_job: got tiles=%0d done=%0d, required 1/14", r_tiles, r_done);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready !== 1'b1 || w_rd_en !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL busy_no_restart: got %0d busy cycles after done, required 0", bad);
        end
        setup(4, 4, 4);
        run_job(0, 200);
        vectors++;
        if (r_tiles != 1) begin
            miscompares++;
            $display("FAIL busy_cfg_kept: got tiles=%0d, required 1", r_tiles);
        end
    endtask

    task automatic test_reset_mid();
        logic [107:0] outs;
        int bad;
        load_cfg(8, 4, 8);
        setup(8, 4, 8);
        @(negedge clk);
        start_comp = 1'b1;
        @(posedge clk);
        #1 start_comp = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        outs = {ready, done, tile_done, w_rd_en, b_rd_en, sa_clear, w_rd_addr, b_rd_addr,
                sa_w_out, sa_b_out, tile_row, tile_col};
        vectors++;
        if (outs !== {1'b1, 107'd0}) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h, required %h", outs, {1'b1, 107'd0});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tile_done || done || !ready) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midreset_abandon: got %0d cycles with activity, required 0", bad);
        end
        setup(0, 0, 0);
        run_job(0, 50);
        vectors++;
        if (r_done != 1 || r_reads != 0) begin
            miscompares++;
            $display("FAIL midreset_cfg_cleared: got done=%0d reads=%0d, required 1/0", r_done, r_reads);
        end
        load_cfg(4, 4, 4);
        setup(4, 4, 4);
        run_job(0, 200);
        vectors++;
        if (r_tiles != 1 || r_done != 14 || r_ready != 15) begin
            miscompares++;
            $display("FAIL midreset_fresh: got tiles=%0d done=%0d ready=%0d, required 1/14/15", r_tiles, r_done, r_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_partial_tiles();
        test_zero_dim();
        test_busy_cmds();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
